ram_burst_ctrl: RTL
===================

// Module: ram_burst_ctrl
// PURPOSE
//  Burst access controller that drives the CBG single-port RAM (ena/wea/addr/din in, dout/read_valid out).
//  Turns one command (base address, length, direction) into a stream of RAM word accesses.
//  Write bursts take words from a valid/ready input stream. Read bursts deliver words on a valid/ready
//  output stream through a 2-entry skid FIFO, so downstream backpressure never drops RAM data.
// PARAMETERS
//  A_W    9    RAM address width (512 words)
//  D_W    32   data width
//  LEN_W  10   burst-length width; max burst is 2**A_W words
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  cmd_valid      in   1      command offered
//  cmd_ready      out  1      1 only in IDLE
//  cmd_write      in   1      1 = write burst, 0 = read burst
//  cmd_base       in   A_W    first word address
//  cmd_len        in   LEN_W  word count; 0 = no-op
//  wr_data        in   D_W    write stream data
//  wr_valid       in   1      write word offered
//  wr_ready       out  1      1 only in WRITE
//  rd_data        out  D_W    read stream data (FIFO head)
//  rd_valid       out  1      FIFO not empty
//  rd_ready       in   1      consumer accepts
//  ram_ena        out  1      RAM enable
//  ram_wea        out  1      RAM write enable
//  ram_addr       out  A_W    RAM address
//  ram_din        out  D_W    RAM write data
//  ram_dout       in   D_W    RAM read data (registered inside RAM)
//  ram_read_valid in   1      RAM read_valid, high the cycle after a read issue
//  busy           out  1      state != IDLE
//  done           out  1      one-cycle pulse at burst completion
// BEHAVIOUR
//  - Reset (async): state=IDLE; counters, FIFO, done and busy cleared; ram_ena/wea=0; rd_valid=0;
//    rd_data, ram_addr and ram_din=0. Reset mid-burst aborts the burst: no done, FIFO contents discarded.
//  - FSM states: IDLE, WRITE, READ, DRAIN.
//    IDLE -> WRITE or READ on cmd_valid & cmd_ready with len != 0. Latch base; cnt = 0.
//    len == 0: stay in IDLE, pulse done on the next cycle, no RAM access.
//  - Addressing: ram_addr = (base + cnt) mod 2**A_W. It wraps 2**A_W-1 -> 0; there is no error on wrap.
//  - WRITE: wr_ready = 1. On wr_valid, drive ram_ena=1, ram_wea=1, ram_din=wr_data combinationally, same cycle.
//    cnt++ per accepted word. The last word moves the FSM to IDLE with done=1 in the following cycle.
//    Throughput is 1 word/clk.
//  - READ: issue ram_ena=1, ram_wea=0 when cnt < len and (occ + inflight - pop) < 2.
//    occ = FIFO count; inflight = 1 if a read was issued last cycle; pop = rd_valid & rd_ready.
//    ram_read_valid pushes ram_dout into the FIFO at the next edge.
//    After the last issue -> DRAIN. In DRAIN, once inflight=0 and occ=0 (after pop) -> IDLE with a done pulse.
//  - Read latency: command accepted at edge E0, issue in the cycle after E0, RAM registers at E1,
//    FIFO captures at E2. rd_valid is high after E2.
//    With rd_ready held at 1, throughput is 1 word/clk. Words are delivered in address order with no loss or duplication.
//  - Simultaneous FIFO push and pop keep occ unchanged. A push while occ==2 cannot happen (credit rule); the bench asserts this.
//  - ram_read_valid seen outside READ/DRAIN is ignored.
//  - cmd_valid outside IDLE is ignored (cmd_ready=0).
// CONFIGURATION
//  BURST_CHKSUM_EN defined:
//    - adds output port chksum (D_W): XOR of every word written (WRITE) or delivered on rd handshake (READ/DRAIN) in the current burst.
//    - cleared to 0 on command accept; valid and stable from the done pulse until the next accept; reset value 0.
//  Not defined: no chksum port and no XOR logic. All other behaviour is identical.
// TESTING
//  1. Assert rst mid-cycle -> all outputs 0 immediately. After release: cmd_ready=1, busy=0.
//  2. Write base=0x1F0, len=32, data=i -> addr 0x1F0..0x1FF then 0x000..0x00F at 1/clk; done pulse 1 clk after last word.
//  3. Read base=0x1F0, len=32, rd_ready=1 -> rd_data 0..31 in order, first rd_valid at E2, 1 word/clk, done once.
//  4. Same read with rd_ready toggling 1,0,0,1 -> all 32 words, none lost or duplicated; occ never exceeds 2.
//  5. cmd_len=0 (read and write) -> done 1 clk later; ram_ena stays 0; cmd_ready back to 1.
//  6. Reset after 5 read words -> rd_valid=0 and busy=0 at once, no done; a new write of len=1 then works normally.
//  7. With BURST_CHKSUM_EN: write 0x1, 0x2, 0x4 -> chksum=0x7 at done; read-back -> chksum=0x7.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// Burst controller for the single-port RAM: one command becomes a stream of word accesses,
// with a 2-entry skid FIFO on the read side. Optional XOR checksum port under `BURST_CHKSUM_EN`.
module ram_burst_ctrl #(
  parameter int A_W   = 9,
  parameter int D_W   = 32,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [A_W-1:0]   cmd_base,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [D_W-1:0]   wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [D_W-1:0]   rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             ram_ena,
  output logic             ram_wea,
  output logic [A_W-1:0]   ram_addr,
  output logic [D_W-1:0]   ram_din,
  input  logic [D_W-1:0]   ram_dout,
  input  logic             ram_read_valid,
  output logic             busy,
  output logic             done
`ifdef BURST_CHKSUM_EN
  ,
  output logic [D_W-1:0]   chksum
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       st_q;
  logic [A_W-1:0]   base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_inc;
  logic             done_q;
  logic             vld_p1;
  logic [D_W-1:0]   fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic [1:0]       occ_nxt;
  logic [2:0]       pend;
  logic             accept;
  logic             wr_fire;
  logic             issue;
  logic             push;
  logic             pop;
  logic [A_W-1:0]   addr_sum;

  // cmd_ready is forced low while reset is held so every output reads 0 during reset.
  assign cmd_ready = (st_q == S_IDLE) && !rst;
  assign wr_ready  = (st_q == S_WRITE);
  assign busy      = (st_q != S_IDLE);
  assign done      = done_q;
  assign accept    = cmd_valid && cmd_ready;
  assign wr_fire   = (st_q == S_WRITE) && wr_valid;

  assign rd_valid = (occ != 2'd0);
  assign rd_data  = fifo_mem[rd_ptr];
  assign pop      = rd_valid && rd_ready;
  assign push     = ram_read_valid && ((st_q == S_READ) || (st_q == S_DRAIN));
  assign occ_nxt  = occ + {1'b0, push} - {1'b0, pop};

  // Credit: words in the FIFO plus the one in flight, minus this cycle's pop, must leave room.
  assign pend    = {1'b0, occ} + {2'b0, vld_p1};
  assign issue   = (st_q == S_READ) && (cnt_q < len_q) && (pend < (3'd2 + {2'b0, pop}));
  assign cnt_inc = cnt_q + 1'b1;

  assign addr_sum = base_q + cnt_q[A_W-1:0];
  assign ram_addr = ((st_q == S_WRITE) || (st_q == S_READ)) ? addr_sum : '0;
  assign ram_din  = wr_fire ? wr_data : '0;
  assign ram_wea  = wr_fire;
  assign ram_ena  = wr_fire || issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= S_IDLE;
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // p0 -> p1: a read issued now has its RAM data valid next cycle
      vld_p1 <= issue;
      case (st_q)
        S_IDLE: begin
          if (accept) begin
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              base_q <= cmd_base;
              len_q  <= cmd_len;
              cnt_q  <= '0;
              st_q   <= cmd_write ? S_WRITE : S_READ;
            end
          end
        end
        S_WRITE: begin
          if (wr_fire) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
              st_q   <= S_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (issue) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) st_q <= S_DRAIN;
          end
        end
        default: begin
          if (!vld_p1 && (occ_nxt == 2'd0)) begin
            st_q   <= S_IDLE;
            done_q <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
    end else begin
      // p1 -> p2: RAM output captured into the skid FIFO
      if (push) begin
        fifo_mem[wr_ptr] <= ram_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ_nxt;
    end
  end

`ifdef BURST_CHKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chksum <= '0;
    end else if (accept) begin
      chksum <= '0;
    end else if (wr_fire) begin
      chksum <= chksum ^ wr_data;
    end else if (pop && ((st_q == S_READ) || (st_q == S_DRAIN))) begin
      chksum <= chksum ^ rd_data;
    end
  end
`endif

endmodule
